// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-FSM side handshake and HI/LO result bus of the multiply/divide unit.
interface mult_div_unit_if
   import mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div0;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, input busy, done, div0, hi, lo);
   modport slave  (input start, op, a, b, output busy, done, div0, hi, lo);
endinterface

// File: rtl/mult_div_unit_datapath.sv
// Shared adder, A|Q|Q-1 shift register, iteration counter and sign fix for
// Booth multiply and restoring divide; HI/LO are held here.
module mdu_datapath
   import mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_op,
   input  logic             i_step,
   input  logic             i_finish,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   localparam int PW = 2*WIDTH + 1;
   localparam int AW = WIDTH + 2;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
      return n ? (~v + ONE) : v;
   endfunction

   logic [PW-1:0]    r_prod;
   logic [WIDTH-1:0] r_m;
   logic             r_op;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [WIDTH-1:0] w_acc;
   logic [WIDTH-1:0] w_q;
   logic             w_q1;
   logic [AW-1:0]    w_x;
   logic [AW-1:0]    w_y;
   logic             w_sub;
   logic [AW-1:0]    w_sum;
   logic             w_borrow;
   logic [PW-1:0]    w_prod_nxt;

   assign w_acc  = r_prod[PW-1:WIDTH+1];
   assign w_q    = r_prod[WIDTH:1];
   assign w_q1   = r_prod[0];
   assign o_last = (r_cnt == LAST_CNT);
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

   // One add/sub per iteration. The adder is two bits wider than the operands
   // so Booth on the most negative multiplicand cannot overflow A.
   always_comb begin
      w_x        = '0;
      w_y        = '0;
      w_sub      = 1'b0;
      w_sum      = '0;
      w_borrow   = 1'b0;
      w_prod_nxt = r_prod;
      if (r_op == OP_MULT) begin
         w_x = {w_acc[WIDTH-1], w_acc[WIDTH-1], w_acc};
         case ({w_q[0], w_q1})
            2'b01:   w_y = {r_m[WIDTH-1], r_m[WIDTH-1], r_m};
            2'b10: begin
               w_y   = {r_m[WIDTH-1], r_m[WIDTH-1], r_m};
               w_sub = 1'b1;
            end
            default: w_y = '0;
         endcase
         w_sum      = w_x + (w_sub ? ~w_y : w_y) + {{(AW-1){1'b0}}, w_sub};
         w_prod_nxt = {w_sum[WIDTH:0], w_q};
      end else begin
         w_x        = {1'b0, w_acc, w_q[WIDTH-1]};
         w_y        = {2'b00, r_m};
         w_sub      = 1'b1;
         w_sum      = w_x + ~w_y + {{(AW-1){1'b0}}, 1'b1};
         w_borrow   = w_sum[AW-1];
         w_prod_nxt = {(w_borrow ? w_x[WIDTH-1:0] : w_sum[WIDTH-1:0]),
                       w_q[WIDTH-2:0], ~w_borrow, 1'b0};
      end
   end

   // Operand capture, iteration and result write-back with sign fix.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prod  <= '0;
         r_m     <= '0;
         r_op    <= OP_MULT;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else if (i_load) begin
         r_op    <= i_op;
         r_cnt   <= '0;
         r_neg_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
         r_neg_r <= i_a[WIDTH-1];
         if (i_op == OP_MULT) begin
            r_m    <= i_a;
            r_prod <= {{WIDTH{1'b0}}, i_b, 1'b0};
         end else begin
            r_m    <= cond_neg(i_b, i_b[WIDTH-1]);
            r_prod <= {{WIDTH{1'b0}}, cond_neg(i_a, i_a[WIDTH-1]), 1'b0};
         end
      end else if (i_step) begin
         r_prod <= w_prod_nxt;
         r_cnt  <= r_cnt + CNT_W'(1);
         if (i_finish) begin
            if (r_op == OP_MULT) begin
               r_hi <= w_prod_nxt[PW-1:WIDTH+1];
               r_lo <= w_prod_nxt[WIDTH:1];
            end else begin
               r_hi <= cond_neg(w_prod_nxt[PW-1:WIDTH+1], r_neg_r);
               r_lo <= cond_neg(w_prod_nxt[WIDTH:1], r_neg_q);
            end
         end
      end
   end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed mult/div unit: control FSM with start/done handshake,
// registered status outputs, datapath holding HI/LO.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);
   state_t r_state;
   logic   r_busy;
   logic   r_done;
   logic   r_div0;

   logic             w_b_zero;
   logic             w_load;
   logic             w_step;
   logic             w_finish;
   logic             w_last;
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_lo;

   assign w_b_zero = (bus.b == '0);

   // Datapath strobes decoded from the current state.
   always_comb begin
      w_load   = 1'b0;
      w_step   = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         IDLE:      w_load = bus.start & ~((bus.op == OP_DIV) & w_b_zero);
         MULT, DIV: begin
            w_step   = 1'b1;
            w_finish = w_last;
         end
         default:   w_load = 1'b0;
      endcase
   end

   // Control FSM; busy/done/div0 are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_div0  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               r_div0 <= 1'b0;
               r_busy <= 1'b0;
               if (bus.start) begin
                  if ((bus.op == OP_DIV) && w_b_zero) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_div0  <= 1'b1;
                  end else if (bus.op == OP_DIV) begin
                     r_state <= DIV;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= MULT;
                     r_busy  <= 1'b1;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            MULT, DIV: begin
               if (w_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= r_state;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_div0  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_div0  <= 1'b0;
            end
         endcase
      end
   end

   mdu_datapath #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_datapath (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_op     (bus.op),
      .i_step   (w_step),
      .i_finish (w_finish),
      .i_a      (bus.a),
      .i_b      (bus.b),
      .o_last   (w_last),
      .o_hi     (w_hi),
      .o_lo     (w_lo)
   );

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.div0 = r_div0;
   assign bus.hi   = w_hi;
   assign bus.lo   = w_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table through a scoreboard,
// plus hand-written lifecycle sequences.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         div0;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         div0;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[12];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = $urandom();
      bus.b     = $urandom();
   endtask

   task automatic wait_done(input int lat0, output int lat, output int bcnt);
      lat  = lat0;
      bcnt = 0;
      while (!bus.done && lat < 100) begin
         if (bus.busy) bcnt++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic pop_check(input string name, input int lat);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s_sb: got empty expected entry", name);
      end else begin
         e = sb_q.pop_front();
         check({name, "_lat"}, 64'(lat), 64'(e.lat));
         check({name, "_hi"}, 64'(bus.hi), 64'(e.hi));
         check({name, "_lo"}, 64'(bus.lo), 64'(e.lo));
         check({name, "_div0"}, 64'(bus.div0), 64'(e.div0));
         check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      end
   endtask

   initial begin
      int lat;
      int bcnt;

      vecs[0]  = '{OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32};
      vecs[1]  = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32};
      vecs[2]  = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 32};
      vecs[3]  = '{OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 32};
      vecs[4]  = '{OP_MULT, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 32};
      vecs[5]  = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32};
      vecs[6]  = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 32};
      vecs[7]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 32};
      vecs[8]  = '{OP_DIV,  32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 32};
      vecs[9]  = '{OP_DIV,  32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 32};
      vecs[10] = '{OP_DIV,  32'h0000_0692, 32'h0000_0020, 32'h0000_0012, 32'h0000_0034, 1'b0, 32};
      vecs[11] = '{OP_DIV,  32'h0000_0005, 32'h0000_0000, 32'h0000_0012, 32'h0000_0034, 1'b1, 0};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_div0", 64'(bus.div0), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         sb_q.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].div0, vecs[i].lat});
         start_op(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(0, lat, bcnt);
         pop_check($sformatf("vec%0d", i), lat);
         check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
         check($sformatf("vec%0d_div0_pulse", i), 64'(bus.div0), 64'd0);
      end

      // Lifecycle: mult 3x4, with start held during DONE (must be ignored).
      sb_q.push_back('{32'h0, 32'd12, 1'b0, 32});
      start_op(OP_MULT, 32'd3, 32'd4);
      wait_done(0, lat, bcnt);
      pop_check("life_3x4", lat);
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.a     = 32'd2;
      bus.b     = 32'd2;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) begin
         check("done_start_ignored_busy", 64'(bus.busy), 64'd0);
         @(posedge clk);
         #1;
      end
      check("done_start_ignored_lo", 64'(bus.lo), 64'd12);

      // Start re-pulsed at iteration 5 with a different operand is ignored.
      sb_q.push_back('{32'h0, 32'd30, 1'b0, 32});
      start_op(OP_MULT, 32'd5, 32'd6);
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = OP_DIV;
      bus.a     = 32'd9;
      bus.b     = 32'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(6, lat, bcnt);
      pop_check("life_restart_ignored", lat);

      // Reset at iteration 10 aborts and clears HI/LO immediately.
      @(posedge clk);
      #1;
      start_op(OP_MULT, 32'd100, 32'd100);
      repeat (10) @(posedge clk);
      #1;
      check("life_busy_before_rst", 64'(bus.busy), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("life_rst_hi", 64'(bus.hi), 64'd0);
      check("life_rst_lo", 64'(bus.lo), 64'd0);
      check("life_rst_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      sb_q.push_back('{32'h0, 32'd143, 1'b0, 32});
      start_op(OP_MULT, 32'd11, 32'd13);
      wait_done(0, lat, bcnt);
      pop_check("life_after_rst", lat);
      check("life_after_rst_busy_cycles", 64'(bcnt), 64'd32);
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit of the multicycle MIPS datapath.
- Executes mult and div, then holds the HI/LO results.
- Sits directly upstream of the register-file write-data source selector: its hi/lo outputs are that selector's HI_out/LO_out inputs, consumed by mfhi/mflo.
- Driven by the main control FSM through a start/done handshake; raises a divide-by-zero flag for the exception logic.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE
- op  input  1  0 = mult, 1 = div
- a  input  WIDTH  rs operand: multiplicand or dividend
- b  input  WIDTH  rt operand: multiplier or divisor
- busy  output  1  high while iterating (MULT or DIV state)
- done  output  1  one-cycle completion pulse
- div0  output  1  one-cycle pulse, coincident with done, on division by zero
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - hi = 0, lo = 0
  - busy = 0, done = 0, div0 = 0
  - counter and internal datapath registers cleared
  - Reset mid-operation aborts the operation; hi/lo return to 0.
- FSM states: IDLE, MULT, DIV, DONE.
- IDLE:
  - start=1, op=0: capture a and b, go to MULT.
  - start=1, op=1, b≠0: capture a and b, go to DIV.
  - start=1, op=1, b=0: go to DONE with div0 set; hi and lo are not written.
- Operands are captured at start. Changes on a and b after the start cycle are ignored.
- MULT:
  - Radix-2 Booth over a 2*WIDTH+1 product register (A | Q | Q-1).
  - One add/sub plus one arithmetic right shift per cycle, WIDTH cycles.
  - On the final iteration edge: hi = product[63:32], lo = product[31:0]; go to DONE.
- DIV:
  - Restoring division on magnitudes |a| and |b|, one quotient bit per cycle, WIDTH cycles.
  - Sign fix applied on the final edge:
    - Quotient is negated when sign(a) ≠ sign(b).
    - Remainder takes the sign of a.
    - Result truncates toward zero.
  - lo = quotient, hi = remainder; go to DONE.
  - 0x80000000 / 0xFFFFFFFF wraps: lo = 0x80000000, hi = 0. No flag.
- DONE: done = 1 (div0 = 1 if divide-by-zero) for exactly one cycle, then IDLE.
- Latency, for start sampled at edge N:
  - mult/div: done high in cycle N+WIDTH+1 (N+33 at default).
  - div by zero: done and div0 high in cycle N+1.
- hi and lo change only on a completing operation or reset. They are held indefinitely otherwise.
- start while busy or in DONE is ignored: no queuing, no restart.
- busy = 1 exactly in MULT/DIV. done and busy are never both high.
- All arithmetic is two's complement, WIDTH bits. Overflow wraps with no flag.

Decomposition:
- Shared package (mdu_pkg) holds:
  - state encoding constants: IDLE, MULT, DIV, DONE
  - op encodings: OP_MULT = 0, OP_DIV = 1
  - WIDTH default
- One sub-module is natural: mdu_datapath.
  - Contains the shared adder/subtractor, the product/remainder shift register, the counter, and the sign-fix logic.
  - Controlled by the FSM in mult_div_unit through load/step/finish strobes.

Test Plan:
- mult a=7, b=0xFFFFFFFD (-3) -> done at start+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
- mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; 0xFFFFFFFF × 0xFFFFFFFF -> hi=0, lo=1.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); 7 / -2 -> lo=0xFFFFFFFD, hi=1.
- div a=5, b=0 with hi/lo preloaded to 0x12/0x34 -> done and div0 high at start+1 for one cycle; hi=0x12, lo=0x34 unchanged.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
- Lifecycle:
  - mult 3×4 completes (lo=12).
  - New mult started; start re-pulsed at iteration 5 with a=9 is ignored; result unaffected.
  - reset asserted at iteration 10 -> hi=lo=0, busy=0 immediately.
  - Start after reset release runs normally.
